// File: rtl/seg7_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
// lead_digit is only used when SEG7_SCAN_LEADING_ZERO_BLANK_EN is defined.
package seg7_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

    // Highest digit position holding a nonzero code; 0 when every digit is zero.
    function automatic int lead_digit(input logic [MAX_DIGITS*DIGIT_W-1:0] disp,
                                      input int num);
        int lead;
        lead = 0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if ((i < num) && (disp[i*DIGIT_W +: DIGIT_W] != 4'd0)) begin
                lead = i;
            end else begin
                lead = lead;
            end
        end
        return lead;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with frame-aligned value commits.
// Optional build macro SEG7_SCAN_LEADING_ZERO_BLANK_EN darkens leading-zero digits.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int TICK_DIV     = 2,
    parameter int BLANK_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] load_data,
    output logic [DIGIT_W-1:0]            digit_code,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic                          frame_done
);

    localparam int CNT_MAX = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DATA_W  = NUM_DIGITS * DIGIT_W;

    localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t            state_r, state_next_s;
    logic [IDX_W-1:0]       idx_r, idx_next_s;
    logic [CNT_W-1:0]       cnt_r, cnt_next_s;
    logic [DATA_W-1:0]      display_r, display_next_s;
    logic [DATA_W-1:0]      pending_r, pending_next_s;
    logic                   pending_full_r, pending_full_next_s;
    logic [NUM_DIGITS-1:0]  digit_sel_r, digit_sel_next_s;
    logic [DIGIT_W-1:0]     digit_code_r, digit_code_next_s;
    logic                   frame_done_r, frame_done_next_s;
    logic                   slot_end_s;

    // Next-state logic: load capture, scan sequencing and frame-boundary commit.
    always_comb begin
        state_next_s        = state_r;
        idx_next_s          = idx_r;
        cnt_next_s          = cnt_r;
        display_next_s      = display_r;
        pending_next_s      = pending_r;
        pending_full_next_s = pending_full_r;
        slot_end_s          = 1'b0;

        if (load_valid && !pending_full_r) begin
            pending_next_s      = load_data;
            pending_full_next_s = 1'b1;
        end else begin
            pending_next_s      = pending_r;
        end

        case (state_r)
            IDLE: begin
                if (pending_full_r) begin
                    display_next_s      = pending_r;
                    pending_full_next_s = 1'b0;
                end else begin
                    display_next_s      = display_r;
                end
                if (enable) begin
                    state_next_s = SHOW;
                    idx_next_s   = '0;
                    cnt_next_s   = '0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHOW: begin
                if (!enable) begin
                    state_next_s = IDLE;
                    idx_next_s   = '0;
                    cnt_next_s   = '0;
                end else if (cnt_r == TICK_LAST) begin
                    if (BLANK_CYCLES == 0) begin
                        slot_end_s = 1'b1;
                    end else begin
                        state_next_s = BLANK;
                        cnt_next_s   = '0;
                    end
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end
            end
            BLANK: begin
                if (!enable) begin
                    state_next_s = IDLE;
                    idx_next_s   = '0;
                    cnt_next_s   = '0;
                end else if (cnt_r == BLANK_LAST) begin
                    slot_end_s = 1'b1;
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_next_s = IDLE;
                idx_next_s   = '0;
                cnt_next_s   = '0;
            end
        endcase

        // Slot wrap: the last slot of a frame is the only place new values land.
        if (slot_end_s) begin
            state_next_s = SHOW;
            cnt_next_s   = '0;
            if (idx_r == IDX_LAST) begin
                idx_next_s = '0;
                if (pending_full_r) begin
                    display_next_s      = pending_r;
                    pending_full_next_s = 1'b0;
                end else begin
                    display_next_s      = display_r;
                end
            end else begin
                idx_next_s = idx_r + IDX_W'(1);
            end
        end else begin
            idx_next_s = idx_next_s;
        end
    end

    // Output decode from the upcoming state so outputs leave a register.
    always_comb begin
        digit_sel_next_s  = '0;
        digit_code_next_s = '0;
        frame_done_next_s = 1'b0;

        case (state_next_s)
            SHOW: begin
                digit_sel_next_s  = NUM_DIGITS'(1) << idx_next_s;
                digit_code_next_s = display_next_s[idx_next_s*DIGIT_W +: DIGIT_W];
`ifdef SEG7_SCAN_LEADING_ZERO_BLANK_EN
                if (idx_next_s > IDX_W'(lead_digit((MAX_DIGITS*DIGIT_W)'(display_next_s), NUM_DIGITS))) begin
                    digit_sel_next_s = '0;
                end else begin
                    digit_sel_next_s = digit_sel_next_s;
                end
`endif
            end
            BLANK: begin
                digit_sel_next_s  = '0;
                digit_code_next_s = digit_code_r;
            end
            default: begin
                digit_sel_next_s  = '0;
                digit_code_next_s = '0;
            end
        endcase

        if (BLANK_CYCLES == 0) begin
            frame_done_next_s = (state_next_s == SHOW) && (idx_next_s == IDX_LAST) &&
                                (cnt_next_s == TICK_LAST);
        end else begin
            frame_done_next_s = (state_next_s == BLANK) && (idx_next_s == IDX_LAST) &&
                                (cnt_next_s == BLANK_LAST);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            idx_r          <= '0;
            cnt_r          <= '0;
            display_r      <= '0;
            pending_r      <= '0;
            pending_full_r <= 1'b0;
            digit_sel_r    <= '0;
            digit_code_r   <= '0;
            frame_done_r   <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            idx_r          <= idx_next_s;
            cnt_r          <= cnt_next_s;
            display_r      <= display_next_s;
            pending_r      <= pending_next_s;
            pending_full_r <= pending_full_next_s;
            digit_sel_r    <= digit_sel_next_s;
            digit_code_r   <= digit_code_next_s;
            frame_done_r   <= frame_done_next_s;
        end
    end

    assign load_ready = !pending_full_r;
    assign digit_sel  = digit_sel_r;
    assign digit_code = digit_code_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: default instance plus a BLANK_CYCLES=0 instance.
// Leading-zero expectations follow SEG7_SCAN_LEADING_ZERO_BLANK_EN.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        enable;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  digit_code;
    logic [3:0]  digit_sel;
    logic        frame_done;

    logic        en_nb;
    logic        load_valid_nb;
    logic        load_ready_nb;
    logic [3:0]  digit_code_nb;
    logic [3:0]  digit_sel_nb;
    logic        frame_done_nb;

    int n_run  = 0;
    int n_fail = 0;

`ifdef SEG7_SCAN_LEADING_ZERO_BLANK_EN
    localparam logic [3:0] LIT_0050 = 4'b0011;
    localparam logic [3:0] LIT_0000 = 4'b0001;
`else
    localparam logic [3:0] LIT_0050 = 4'b1111;
    localparam logic [3:0] LIT_0000 = 4'b1111;
`endif

    seg7_scan_ctrl #(.NUM_DIGITS(4), .TICK_DIV(2), .BLANK_CYCLES(1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .digit_code (digit_code),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    seg7_scan_ctrl #(.NUM_DIGITS(4), .TICK_DIV(2), .BLANK_CYCLES(0)) dut_nb (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (en_nb),
        .load_valid (load_valid_nb),
        .load_ready (load_ready_nb),
        .load_data  (load_data),
        .digit_code (digit_code_nb),
        .digit_sel  (digit_sel_nb),
        .frame_done (frame_done_nb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 12-cycle frame: 3 cycles per slot (2 lit + 1 blank); optional load in cycle 1.
    task automatic check_frame(input string tag, input logic [15:0] data, input logic [3:0] lit,
                               input bit do_load, input logic [15:0] new_data);
        for (int c = 0; c < 12; c++) begin
            int slot;
            int phase;
            slot  = c / 3;
            phase = c % 3;
            tick();
            chk({tag, " sel"}, 32'(digit_sel), (phase < 2 && lit[slot]) ? 32'(1 << slot) : 32'd0);
            chk({tag, " code"}, 32'(data >> (slot * 4)) & 32'hF, 32'(digit_code));
            chk({tag, " frame_done"}, 32'(frame_done), (c == 11) ? 32'd1 : 32'd0);
            if (do_load && c == 0) begin
                load_valid = 1'b1;
                load_data  = new_data;
            end else if (do_load && c == 1) begin
                chk({tag, " ready after load"}, 32'(load_ready), 32'd0);
                load_valid = 1'b0;
            end else if (do_load && c == 11) begin
                chk({tag, " ready held"}, 32'(load_ready), 32'd0);
            end else if (!do_load && c == 0) begin
                chk({tag, " ready"}, 32'(load_ready), 32'd1);
            end
        end
    endtask

    initial begin
        enable        = 1'b0;
        en_nb         = 1'b0;
        load_valid    = 1'b0;
        load_valid_nb = 1'b0;
        load_data     = 16'h0000;
        #2;
        reset_n = 1'b0;
        tick();
        tick();
        chk("rst sel", 32'(digit_sel), 32'd0);
        chk("rst code", 32'(digit_code), 32'd0);
        chk("rst frame_done", 32'(frame_done), 32'd0);
        chk("rst ready", 32'(load_ready), 32'd1);
        chk("rst nb sel", 32'(digit_sel_nb), 32'd0);
        reset_n = 1'b1;
        tick();

        // Load 0x4321 while idle, then scan; 0x9999 arrives mid-frame.
        load_valid = 1'b1;
        load_data  = 16'h4321;
        tick();
        chk("t1 ready full", 32'(load_ready), 32'd0);
        load_valid = 1'b0;
        tick();
        chk("t1 ready commit", 32'(load_ready), 32'd1);
        chk("t1 idle sel", 32'(digit_sel), 32'd0);
        enable = 1'b1;
        check_frame("t1", 16'h4321, 4'hF, 1'b1, 16'h9999);
        check_frame("t2", 16'h9999, 4'hF, 1'b0, 16'h0000);

        // Drop enable during digit 2 SHOW, then restart.
        for (int i = 0; i < 7; i++) tick();
        chk("t3 d2 sel", 32'(digit_sel), 32'd4);
        chk("t3 d2 code", 32'(digit_code), 32'd9);
        enable = 1'b0;
        tick();
        chk("t3 off sel", 32'(digit_sel), 32'd0);
        chk("t3 off code", 32'(digit_code), 32'd0);
        chk("t3 off frame_done", 32'(frame_done), 32'd0);
        tick();
        chk("t3 idle sel", 32'(digit_sel), 32'd0);
        enable = 1'b1;
        check_frame("t3", 16'h9999, 4'hF, 1'b0, 16'h0000);

        // Asynchronous reset mid-SHOW with a pending load.
        tick();
        chk("t4 show sel", 32'(digit_sel), 32'd1);
        load_valid = 1'b1;
        load_data  = 16'h5555;
        tick();
        chk("t4 pending ready", 32'(load_ready), 32'd0);
        load_valid = 1'b0;
        reset_n    = 1'b0;
        #1;
        chk("t4 async sel", 32'(digit_sel), 32'd0);
        chk("t4 async ready", 32'(load_ready), 32'd1);
        chk("t4 async code", 32'(digit_code), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("t4 restart sel", 32'(digit_sel), 32'd1);
        chk("t4 restart code", 32'(digit_code), 32'd0);

        // Leading-zero cases.
        enable = 1'b0;
        tick();
        load_valid = 1'b1;
        load_data  = 16'h0050;
        tick();
        load_valid = 1'b0;
        tick();
        enable = 1'b1;
        check_frame("t5a", 16'h0050, LIT_0050, 1'b0, 16'h0000);
        enable = 1'b0;
        tick();
        load_valid = 1'b1;
        load_data  = 16'h0000;
        tick();
        load_valid = 1'b0;
        tick();
        enable = 1'b1;
        check_frame("t5b", 16'h0000, LIT_0000, 1'b0, 16'h0000);

        // BLANK_CYCLES=0 instance: 8-cycle frame, never dark while enabled.
        load_valid_nb = 1'b1;
        load_data     = 16'h8765;
        tick();
        load_valid_nb = 1'b0;
        tick();
        en_nb = 1'b1;
        for (int c = 0; c < 8; c++) begin
            int slot;
            slot = c / 2;
            tick();
            chk("t6 sel", 32'(digit_sel_nb), 32'(1 << slot));
            chk("t6 code", 32'(digit_code_nb), 32'(16'h8765 >> (slot * 4)) & 32'hF);
            chk("t6 frame_done", 32'(frame_done_nb), (c == 7) ? 32'd1 : 32'd0);
        end
        tick();
        chk("t6 wrap sel", 32'(digit_sel_nb), 32'd1);
        chk("t6 wrap frame_done", 32'(frame_done_nb), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
